// File: rtl/char_gen_scroll.sv
// Character generator with hardware vertical scroll, blinking cursor and per-cell blink.
// Maps (pixel_x, pixel_y) to a 12-bit colour through a COLS x ROWS cell RAM and an 8x16 font ROM.
module char_gen_scroll #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 30,
  parameter int ADDR_W       = 12,
  localparam int ROW_W       = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              pixel_active,
  input  logic              frame_start,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_write_value,
  output logic [31:0]       data_read_value,
  input  logic              scroll_we,
  input  logic [ROW_W-1:0]  scroll_row,
  input  logic              cursor_en,
  input  logic [ADDR_W-1:0] cursor_addr,
  output logic [11:0]       pixel_out,
  output logic              pixel_out_valid
);

  localparam int DEPTH = COLS * ROWS;
  localparam int LW    = ADDR_W + 8;
  localparam int BC_W  = $clog2(BLINK_FRAMES + 1);

  localparam logic [ADDR_W:0]  DEPTH_A    = (ADDR_W + 1)'(DEPTH);
  localparam logic [LW-1:0]    DEPTH_L    = LW'(DEPTH);
  localparam logic [LW-1:0]    COLS_L     = LW'(COLS);
  localparam logic [6:0]       ROWS_7     = 7'(ROWS);
  localparam logic [ROW_W:0]   ROWS_R     = (ROW_W + 1)'(ROWS);
  localparam logic [10:0]      X_LIM      = 11'(COLS * 8);
  localparam logic [10:0]      Y_LIM      = 11'(ROWS * 16);
  localparam logic [BC_W-1:0]  BLINK_LAST = BC_W'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic [11:0] bg;
    logic [11:0] fg;
    logic        blink;
    logic [6:0]  code;
  } cell_t;

  // 8x16 glyphs: 'A', a full block at 0x7F, blanks at 0x00/0x20, a row/code test pattern elsewhere.
  function automatic logic [7:0] font_rom(input logic [6:0] code, input logic [3:0] row);
    logic [7:0] g;
    g = 8'h00;
    case (code)
      7'h41: begin
        case (row)
          4'd2:                             g = 8'h10;
          4'd3:                             g = 8'h38;
          4'd4:                             g = 8'h6C;
          4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11: g = 8'hC6;
          4'd7:                             g = 8'hFE;
          default:                          g = 8'h00;
        endcase
      end
      7'h7F:        g = 8'hFF;
      7'h00, 7'h20: g = 8'h00;
      default:      g = {row, code[3:0]};
    endcase
    return g;
  endfunction

  logic [31:0]      mem [DEPTH];
  logic [ROW_W-1:0] scroll_shadow, active_scroll;
  logic [BC_W-1:0]  blink_cnt;
  logic             blink_phase;

  // Stage 0: cell lookup, window and cursor decode.
  logic [6:0]    col, row_sum, prow;
  logic [5:0]    lrow;
  logic [LW-1:0] pix_addr, lin_addr;
  logic          in_window_s0, cursor_s0, data_in_range;

  assign col          = pixel_x[9:3];
  assign lrow         = pixel_y[9:4];
  assign row_sum      = {1'b0, lrow} + 7'(active_scroll);
  assign prow         = (row_sum >= ROWS_7) ? row_sum - ROWS_7 : row_sum;
  assign pix_addr     = LW'(prow) * COLS_L + LW'(col);
  assign lin_addr     = LW'(lrow) * COLS_L + LW'(col);
  assign in_window_s0 = pixel_active && ({1'b0, pixel_x} < X_LIM) && ({1'b0, pixel_y} < Y_LIM);
  assign cursor_s0    = cursor_en && ({1'b0, cursor_addr} < DEPTH_A) && (LW'(cursor_addr) == lin_addr);
  assign data_in_range = {1'b0, data_addr} < DEPTH_A;

  cell_t       cell_s1, cell_s2;
  logic [2:0]  x_s1, x_s2;
  logic [3:0]  y_s1;
  logic [7:0]  glyph_s2;
  logic        in_window_s1, in_window_s2, cursor_s1, cursor_s2;

  // NOTE: the cell RAM and the datapath registers carry no reset; every use is qualified by the reset control bits.
  always_ff @(posedge clk) begin
    if (data_we && data_in_range)
      mem[data_addr] <= data_write_value;
    cell_s1  <= (pix_addr < DEPTH_L) ? cell_t'(mem[pix_addr[ADDR_W-1:0]]) : '0;
    x_s1     <= pixel_x[2:0];
    y_s1     <= pixel_y[3:0];
    glyph_s2 <= font_rom(cell_s1.code, y_s1);
    cell_s2  <= cell_s1;
    x_s2     <= x_s1;
  end

  // NOTE: sequential state uses non-blocking assignments so each register samples pre-edge values (read-first RAM included).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_read_value <= '0;
      in_window_s1    <= 1'b0;
      in_window_s2    <= 1'b0;
      cursor_s1       <= 1'b0;
      cursor_s2       <= 1'b0;
    end else begin
      data_read_value <= data_in_range ? mem[data_addr] : '0;
      in_window_s1    <= in_window_s0;
      in_window_s2    <= in_window_s1;
      cursor_s1       <= cursor_s0;
      cursor_s2       <= cursor_s1;
    end
  end

  // Shadow lands in the active register only at frame start, so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scroll_shadow <= '0;
      active_scroll <= '0;
      blink_cnt     <= '0;
      blink_phase   <= 1'b0;
    end else begin
      if (frame_start) begin
        active_scroll <= scroll_shadow;
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
      if (scroll_we && ({1'b0, scroll_row} < ROWS_R))
        scroll_shadow <= scroll_row;
    end
  end

  logic        fg_bit;
  logic [11:0] colour;

  assign fg_bit = glyph_s2[3'd7 - x_s2];

  // NOTE: colour is defaulted before the priority chain so no path can infer a latch.
  always_comb begin
    colour = 12'h000;
    if (!in_window_s2)
      colour = 12'h000;
    else if (cell_s2.blink && blink_phase)
      colour = cell_s2.bg;
    else if (cursor_s2 && blink_phase)
      colour = fg_bit ? cell_s2.bg : cell_s2.fg;
    else
      colour = fg_bit ? cell_s2.fg : cell_s2.bg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_out       <= '0;
      pixel_out_valid <= 1'b0;
    end else begin
      pixel_out       <= colour;
      pixel_out_valid <= in_window_s2;
    end
  end

endmodule

// File: tb/tb_char_gen_scroll.sv
// Scoreboard bench for char_gen_scroll: expected pixels and bus reads are queued at drive
// time from a behavioural model and compared when the DUT produces them.
module tb_char_gen_scroll;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int BF    = 2;
  localparam int AW    = 12;
  localparam int DEPTH = COLS * ROWS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [9:0]    pixel_x = '0, pixel_y = '0;
  logic          pixel_active = 1'b0, frame_start = 1'b0;
  logic          data_we = 1'b0;
  logic [AW-1:0] data_addr = '0;
  logic [31:0]   data_write_value = '0;
  logic [31:0]   data_read_value;
  logic          scroll_we = 1'b0;
  logic [4:0]    scroll_row = '0;
  logic          cursor_en = 1'b0;
  logic [AW-1:0] cursor_addr = '0;
  logic [11:0]   pixel_out;
  logic          pixel_out_valid;

  always #5 clk = ~clk;

  char_gen_scroll #(.COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(BF), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_active(pixel_active), .frame_start(frame_start),
    .data_we(data_we), .data_addr(data_addr), .data_write_value(data_write_value),
    .data_read_value(data_read_value),
    .scroll_we(scroll_we), .scroll_row(scroll_row),
    .cursor_en(cursor_en), .cursor_addr(cursor_addr),
    .pixel_out(pixel_out), .pixel_out_valid(pixel_out_valid)
  );

  typedef struct { logic v; logic [11:0] p; } pix_exp_t;
  typedef struct { bit chk; logic [31:0] val; } bus_exp_t;

  pix_exp_t pix_q[$];
  bus_exp_t bus_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [31:0] mem_m [DEPTH];
  int shadow_m = 0, scroll_m = 0, cnt_m = 0;
  bit phase_m = 1'b0;

  // Stimulus for the next step; we/scroll_we/frame_start are one-shot.
  bit          b_we = 0, b_chk = 0, s_we = 0, f_st = 0, c_en = 0;
  int          b_addr = 0, s_row = 0, c_addr = 0;
  logic [31:0] b_wd = '0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] font_m(input int code, input int r);
    logic [127:0] glyph_a;
    glyph_a = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
    if (code == 'h41) return glyph_a[127 - 8*r -: 8];
    if (code == 'h7F) return 8'hFF;
    if (code == 0 || code == 'h20) return 8'h00;
    return 8'(((r & 15) << 4) | (code & 15));
  endfunction

  function automatic pix_exp_t expect_pix(input int x, input int y, input bit act);
    pix_exp_t    e;
    logic [31:0] w;
    logic [7:0]  g;
    int          lrow, col, prow;
    bit          b, cur;
    e.v = 1'b0;
    e.p = 12'h000;
    if (!act || x >= COLS*8 || y >= ROWS*16) return e;
    lrow = y / 16;
    col  = x / 8;
    prow = (lrow + scroll_m) % ROWS;
    w    = mem_m[prow*COLS + col];
    g    = font_m(int'(w[6:0]), y % 16);
    b    = g[7 - (x % 8)];
    cur  = c_en && (c_addr == lrow*COLS + col);
    e.v  = 1'b1;
    if (w[7] && phase_m)    e.p = w[31:20];
    else if (cur && phase_m) e.p = b ? w[31:20] : w[19:8];
    else                     e.p = b ? w[19:8] : w[31:20];
    return e;
  endfunction

  task automatic step(input int x, input int y, input bit act);
    pix_exp_t pe;
    bus_exp_t be;
    @(negedge clk);
    if (pix_q.size() == 3) begin
      pe = pix_q.pop_front();
      check("pix_valid", 32'(pixel_out_valid), 32'(pe.v));
      check("pix_out", 32'(pixel_out), 32'(pe.p));
    end
    if (bus_q.size() == 1) begin
      be = bus_q.pop_front();
      if (be.chk) check("rd_data", data_read_value, be.val);
    end
    pix_q.push_back(expect_pix(x, y, act));
    be.chk = b_chk;
    be.val = (b_addr < DEPTH) ? mem_m[b_addr] : 32'h0;
    bus_q.push_back(be);
    pixel_x          = 10'(x);
    pixel_y          = 10'(y);
    pixel_active     = act;
    frame_start      = f_st;
    data_we          = b_we;
    data_addr        = AW'(b_addr);
    data_write_value = b_wd;
    scroll_we        = s_we;
    scroll_row       = 5'(s_row);
    cursor_en        = c_en;
    cursor_addr      = AW'(c_addr);
    if (b_we && b_addr < DEPTH) mem_m[b_addr] = b_wd;
    if (f_st) begin
      scroll_m = shadow_m;
      if (cnt_m == BF - 1) begin
        cnt_m   = 0;
        phase_m = ~phase_m;
      end else begin
        cnt_m++;
      end
    end
    if (s_we && s_row < ROWS) shadow_m = s_row;
    b_we = 0;
    s_we = 0;
    f_st = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 1'b0);
  endtask

  task automatic wr(input int a, input logic [31:0] d, input bit chk);
    b_we = 1; b_addr = a; b_wd = d; b_chk = chk;
    step(0, 0, 1'b0);
  endtask

  task automatic rd(input int a);
    b_addr = a; b_chk = 1;
    step(0, 0, 1'b0);
  endtask

  task automatic frame();
    idle(3);
    f_st = 1;
    step(0, 0, 1'b0);
    idle(3);
  endtask

  task automatic render(input int lrow, input int col, input int r);
    for (int xo = 0; xo < 8; xo++) step(col*8 + xo, lrow*16 + r, 1'b1);
  endtask

  initial begin
    // Outputs held at zero while in reset, even with active pixels driven.
    pixel_active = 1'b1;
    pixel_x      = 10'd16;
    pixel_y      = 10'd16;
    repeat (3) begin
      @(negedge clk);
      check("rst_pix_out", 32'(pixel_out), 32'h0);
      check("rst_valid", 32'(pixel_out_valid), 32'h0);
      check("rst_rd", data_read_value, 32'h0);
    end
    #1 rst_n = 1'b1;

    for (int a = 0; a < DEPTH; a++) wr(a, 32'h000FFF20, 1'b0);
    b_chk = 0;
    idle(2);

    // Glyph render of 'A' row 5, then a few other cells and patterns.
    wr(0, 32'hF000F041, 1'b1);
    rd(0);
    render(0, 0, 5);
    wr(1, 32'h0F0F007F, 1'b1);
    wr(2, 32'h123ABC33, 1'b1);
    wr(3, 32'h00FFF020, 1'b1);
    for (int c = 0; c < 4; c++) render(0, c, 7);
    render(0, 2, 0);
    render(0, 0, 2);

    // Read-first collision and out-of-range accesses.
    wr(100, 32'h12345678, 1'b1);
    rd(100);
    wr(2400, 32'hDEADBEEF, 1'b1);
    rd(2400);
    rd(4095);
    rd(2399);

    // Scroll: mid-frame request only takes effect at frame_start.
    wr(2320, 32'h00FF007F, 1'b1);
    s_we = 1; s_row = 29;
    idle(1);
    render(0, 0, 3);
    frame();
    render(0, 0, 3);
    render(1, 0, 5);
    s_we = 1; s_row = 30;
    idle(1);
    frame();
    render(0, 0, 3);
    render(1, 0, 5);
    // Simultaneous load and frame_start: active takes the old shadow.
    idle(3);
    s_we = 1; s_row = 3; f_st = 1;
    step(0, 0, 1'b0);
    idle(3);
    render(0, 0, 3);
    frame();
    render(0, 0, 3);
    render(27, 0, 5);
    s_we = 1; s_row = 0;
    idle(1);
    frame();

    // Blink attribute and cursor over several blink half-periods.
    wr(81, 32'h00FFF041, 1'b1);
    wr(5, 32'hF000F0C1, 1'b1);
    c_en = 1; c_addr = 81;
    idle(1);
    for (int i = 0; i < 6; i++) begin
      render(1, 1, 5);
      render(0, 5, 5);
      render(0, 5, 7);
      render(0, 0, 5);
      frame();
    end
    c_addr = 2400;
    idle(1);
    render(0, 0, 5);
    c_addr = 81;
    idle(1);

    // Out-of-window pixels with pixel_active high.
    for (int x = 636; x < 648; x++) step(x, 100, 1'b1);
    for (int x = 792; x < 800; x++) step(x, 100, 1'b1);
    for (int y = 478; y < 484; y++) step(8, y, 1'b1);
    step(1023, 1023, 1'b1);
    idle(3);

    // Reset mid-stream: outputs clear at once, pipeline refills afterwards.
    if (!phase_m) frame();
    render(1, 1, 5);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pix_out", 32'(pixel_out), 32'h0);
    check("midrst_valid", 32'(pixel_out_valid), 32'h0);
    check("midrst_rd", data_read_value, 32'h0);
    pix_q.delete();
    bus_q.delete();
    shadow_m = 0; scroll_m = 0; cnt_m = 0; phase_m = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    render(1, 1, 5);
    render(0, 5, 5);
    rd(0);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/char_gen_scroll.md
Name: char_gen_scroll

Overview:
- Single-clock, parametrised successor to the VGA character generator.
- Maps each (pixel_x, pixel_y) to a 12-bit colour through a COLS x ROWS character/colour memory and the 8x16 font_rom.
- Adds hardware vertical scroll with frame-synchronous update, a blinking hardware cursor, a per-character blink attribute, out-of-window blanking and a fixed, valid-tagged output pipeline.
- Sits between the VGA timing generator and the colour output register. The data port faces the I/O system bus.

Parameters:
- COLS, 80, characters per row (8 pixels each); COLS*8 <= 1024.
- ROWS, 30, character rows (16 pixels each); ROWS*16 <= 1024.
- BLINK_FRAMES, 30, frames per blink half-period; >= 1.
- ADDR_W, 12, data/cursor address width; 2**ADDR_W >= COLS*ROWS.

Ports:
- clk  in  1  pixel and bus clock.
- rst_n  in  1  asynchronous active-low reset.
- pixel_x  in  10  current pixel column.
- pixel_y  in  10  current pixel row.
- pixel_active  in  1  visible-region flag from the timing generator.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- data_we  in  1  character memory write enable.
- data_addr  in  ADDR_W  linear cell address, row*COLS+col (physical).
- data_write_value  in  32  cell word.
- data_read_value  out  32  cell word at data_addr.
- scroll_we  in  1  load scroll shadow register.
- scroll_row  in  ROW_W=$clog2(ROWS)  requested first displayed physical row.
- cursor_en  in  1  cursor display enable.
- cursor_addr  in  ADDR_W  cursor cell, logical screen address (row*COLS+col).
- pixel_out  out  12  pixel colour.
- pixel_out_valid  out  1  pixel_out corresponds to an active pixel.

Behaviour:
- Cell word layout:
  - [31:20] background colour.
  - [19:8] foreground colour.
  - [7] blink attribute.
  - [6:0] character code.
- Reset (async assert, sync release): pixel_out=0, pixel_out_valid=0, data_read_value=0, scroll shadow=0, active scroll=0, blink counter=0, blink_phase=0. Memory contents are not reset.
- Data port:
  - Single-clock RAM.
  - data_read_value is registered, 1-cycle latency.
  - Read-first: a write and a read to the same address in one cycle return the old word, and the new word appears on the next cycle.
  - Writes to addresses >= COLS*ROWS are ignored; reads there return 0.
- Pixel pipeline, fixed latency 3 cycles from pixel_x/pixel_y/pixel_active to pixel_out/pixel_out_valid:
  - Cycle 0:
    - col = pixel_x[9:3], lrow = pixel_y[9:4].
    - prow = lrow + active_scroll, minus ROWS if >= ROWS (single conditional subtract; no divider).
    - RAM read address = prow*COLS+col.
    - in_window = pixel_active && pixel_x < COLS*8 && pixel_y < ROWS*16.
    - is_cursor = cursor_en && (lrow*COLS+col == cursor_addr).
  - Cycle 1: font_rom address = {code[6:0], pixel_y[3:0]}, read with 1-cycle latency.
  - Cycle 2: select glyph bit 7-x[2:0] using the x[2:0] delayed 2 cycles, giving fg_bit.
  - Cycle 3: register pixel_out and pixel_out_valid (= in_window delayed 3 cycles).
- Side-band alignment: in_window, is_cursor, x[2:0] and the cell word travel in delay registers aligned to their stage.
- Colour rule, evaluated in order:
  - !in_window gives 0x000.
  - Blink attribute set and blink_phase=1 gives bg.
  - is_cursor and blink_phase=1 gives the inverse: fg where the glyph is 0, bg where it is 1.
  - Otherwise fg_bit ? fg : bg.
- Scroll:
  - scroll_we with scroll_row < ROWS loads the shadow; scroll_row >= ROWS is ignored.
  - The shadow copies to the active scroll only on frame_start, so there is no mid-frame tear.
  - If scroll_we and frame_start occur in the same cycle, active takes the old shadow and the shadow takes the new value.
- Blink:
  - The counter increments on frame_start.
  - When the counter == BLINK_FRAMES-1 and frame_start is asserted, it wraps to 0 and blink_phase toggles.
- Reset mid-frame: outputs go to 0 immediately; the pipeline refills and valid output resumes 3 cycles after the first active input post-reset.
- Cursor: cursor_addr >= COLS*ROWS never matches.

Test Plan:
- Reset and blanking: hold rst_n=0, drive active pixels, release -> pixel_out=0/valid=0 during reset; with pixel_active=0, valid=0 and pixel_out=0x000 thereafter.
- Glyph render: write addr 0 = 0xF00_0F0_41 ('A', bg red, fg green), sweep x=0..7 at y=5 -> pixel_out exactly 3 cycles later equals 0x0F0 where the font_rom 'A' row 5 bit is set, else 0xF00.
- Read-first collision: write 0x12345678 to addr 100 while reading addr 100 -> read shows the prior word, next cycle shows 0x12345678; write to addr 2400 (COLS=80, ROWS=30) -> ignored, reads 0.
- Scroll:
  - Set scroll_row=29 mid-frame -> display unchanged until frame_start; afterwards pixel_y=0 shows physical row 29 and pixel_y=16 shows physical row 0 (wrap).
  - scroll_row=30 -> ignored.
- Blink: BLINK_FRAMES=2, cursor_en=1 at cursor_addr 81, cell with bit7=1 at addr 5 -> phase toggles every 2 frame_start pulses; in phase 1 the cursor cell is colour-inverted and cell 5 is solid bg; in phase 0 both render normally.
- Out of window: pixel_x=640..799 or pixel_y>=480 with pixel_active=1 -> pixel_out=0x000, valid=0.
